// File: rtl/sik_pkg.sv
// Shared types and constants for the SIK fetch stage.
// Optional prefix folding is enabled by defining SIK_PRE_FOLD_EN.
package sik_pkg;

    localparam int unsigned WORD   = 16;
    localparam int unsigned OPCODE = 4;
    localparam int unsigned PRE    = 4;

    localparam logic [OPCODE-1:0] OPpre = 4'b1111;
    localparam logic [WORD-1:0]   NOOP  = 16'h0000;

    localparam logic [WORD-1:0] T0_RESET_PC_DEF = 16'h0000;
    localparam logic [WORD-1:0] T1_RESET_PC_DEF = 16'h8000;

    // True when the word is a prefix instruction
    function automatic logic is_pre(input logic [WORD-1:0] inst);
        return inst[WORD-1 -: OPCODE] == OPpre;
    endfunction

endpackage

// File: rtl/sik_fetch_ctx.sv
// Per-thread fetch context: PC, sticky halt flag and (with SIK_PRE_FOLD_EN) the
// folded prefix register with its pending flag.
module sik_fetch_ctx
    import sik_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue,
    input  logic            redirect,
    input  logic [WORD-1:0] redirect_pc,
    input  logic            halt,
`ifdef SIK_PRE_FOLD_EN
    input  logic            pre_load,
    input  logic [PRE-1:0]  pre_val,
    input  logic            pre_consume,
    output logic [PRE-1:0]  pre,
    output logic            pre_pend,
`endif
    output logic [WORD-1:0] pc,
    output logic            halted
);

    logic [WORD-1:0] pc_q, pc_d;
    logic            halted_q;

    // Redirect beats the sequential increment
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d = pc_q + 16'd1;
        end
    end

    // PC and sticky halt state
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (halt) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign pc     = pc_q;
    assign halted = halted_q;

`ifdef SIK_PRE_FOLD_EN
    logic [PRE-1:0] pre_q;
    logic           pend_q;

    // Latest prefix wins; redirect/halt drop any unconsumed prefix
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q  <= '0;
            pend_q <= 1'b0;
        end else if (redirect || halt) begin
            pend_q <= 1'b0;
        end else if (pre_load) begin
            pre_q  <= pre_val;
            pend_q <= 1'b1;
        end else if (pre_consume) begin
            pend_q <= 1'b0;
        end
    end

    assign pre      = pre_q;
    assign pre_pend = pend_q;
`endif

endmodule

// File: rtl/sik_fetch.sv
// Two-thread round-robin instruction fetch for the SIK stack processor.
// Define SIK_PRE_FOLD_EN to fold prefix words into the following instruction.
module sik_fetch
    import sik_pkg::*;
#(
    parameter logic [WORD-1:0] T0_RESET_PC = T0_RESET_PC_DEF,
    parameter logic [WORD-1:0] T1_RESET_PC = T1_RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    output logic [WORD-1:0] imem_addr,
    input  logic [WORD-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic            redirect_tid,
    input  logic [WORD-1:0] redirect_pc,
    input  logic            halt_req,
    input  logic            halt_tid,
    output logic            out_valid,
    output logic [WORD-1:0] out_inst,
    output logic [WORD-1:0] out_pc,
    output logic            out_tid,
    output logic [PRE-1:0]  out_pre,
    output logic            out_pre_valid,
    output logic [1:0]      thread_halted,
    output logic            halted
);

    logic            turn_q;
    logic            f1_valid_q, f1_tid_q;
    logic [WORD-1:0] f1_pc_q;
    logic            out_valid_q, out_tid_q;
    logic [WORD-1:0] out_inst_q, out_pc_q;

    logic [1:0]      redir, halt, squash, issue_vec;
    logic [WORD-1:0] pc [2];
    logic            sel_tid, do_issue, f2_live, emit;

`ifdef SIK_PRE_FOLD_EN
    logic [PRE-1:0] pre [2];
    logic [1:0]     pre_pend, pre_load, pre_consume;
    logic           f2_pre;
    logic [PRE-1:0] out_pre_q;
    logic           out_pre_valid_q;
`endif

    // Decode per-thread events, pick the issuing thread, classify the F2 word
    always_comb begin
        redir     = 2'b00;
        halt      = 2'b00;
        issue_vec = 2'b00;
        if (redirect_valid) redir[redirect_tid] = 1'b1;
        if (halt_req)       halt[halt_tid]      = 1'b1;
        squash   = redir | halt;
        sel_tid  = thread_halted[turn_q] ? ~turn_q : turn_q;
        do_issue = !stall && (thread_halted != 2'b11);
        issue_vec[sel_tid] = do_issue;
        f2_live  = f1_valid_q && !squash[f1_tid_q];
`ifdef SIK_PRE_FOLD_EN
        f2_pre      = f2_live && is_pre(imem_rdata);
        emit        = f2_live && !f2_pre;
        pre_load    = 2'b00;
        pre_consume = 2'b00;
        pre_load[f1_tid_q]    = !stall && f2_pre;
        pre_consume[f1_tid_q] = !stall && emit;
`else
        emit = f2_live;
`endif
    end

    for (genvar i = 0; i < 2; i++) begin : g_ctx
        sik_fetch_ctx #(
            .RESET_PC (i == 0 ? T0_RESET_PC : T1_RESET_PC)
        ) u_ctx (
            .clk         (clk),
            .reset       (reset),
            .issue       (issue_vec[i]),
            .redirect    (redir[i]),
            .redirect_pc (redirect_pc),
            .halt        (halt[i]),
`ifdef SIK_PRE_FOLD_EN
            .pre_load    (pre_load[i]),
            .pre_val     (imem_rdata[PRE-1:0]),
            .pre_consume (pre_consume[i]),
            .pre         (pre[i]),
            .pre_pend    (pre_pend[i]),
`endif
            .pc          (pc[i]),
            .halted      (thread_halted[i])
        );
    end

    // F1/F2 pipe; squashes still clear held entries while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            turn_q      <= 1'b0;
            f1_valid_q  <= 1'b0;
            f1_tid_q    <= 1'b0;
            f1_pc_q     <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= NOOP;
            out_pc_q    <= '0;
            out_tid_q   <= 1'b0;
        end else if (stall) begin
            if (squash[f1_tid_q])  f1_valid_q  <= 1'b0;
            if (squash[out_tid_q]) out_valid_q <= 1'b0;
        end else begin
            f1_valid_q <= do_issue && !squash[sel_tid];
            if (do_issue) begin
                f1_pc_q  <= pc[sel_tid];
                f1_tid_q <= sel_tid;
                turn_q   <= ~turn_q;
            end
            out_valid_q <= emit;
            out_inst_q  <= imem_rdata;
            out_pc_q    <= f1_pc_q;
            out_tid_q   <= f1_tid_q;
        end
    end

`ifdef SIK_PRE_FOLD_EN
    // Attach any pending prefix to the next emitted instruction of that thread
    always_ff @(posedge clk) begin
        if (reset) begin
            out_pre_q       <= '0;
            out_pre_valid_q <= 1'b0;
        end else if (stall) begin
            if (squash[out_tid_q]) out_pre_valid_q <= 1'b0;
        end else begin
            out_pre_q       <= pre[f1_tid_q];
            out_pre_valid_q <= emit && pre_pend[f1_tid_q];
        end
    end

    assign out_pre       = out_pre_q;
    assign out_pre_valid = out_pre_valid_q;
`else
    assign out_pre       = '0;
    assign out_pre_valid = 1'b0;
`endif

    assign imem_addr = f1_pc_q;
    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_pc    = out_pc_q;
    assign out_tid   = out_tid_q;
    assign halted    = (thread_halted == 2'b11) && !f1_valid_q && !out_valid_q;

endmodule

// File: tb/tb_sik_fetch.sv
// Scoreboard bench for sik_fetch: expected outputs are queued per phase and
// matched as decode accepts them. A second instance checks PC wrap-around.
module tb_sik_fetch;

    typedef struct packed {
        logic        tid;
        logic [15:0] pc;
        logic [15:0] inst;
        logic [3:0]  pre;
        logic        pre_v;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic        redirect_tid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt_req = 1'b0;
    logic        halt_tid = 1'b0;

    logic [15:0] imem_addr, imem_rdata, out_inst, out_pc;
    logic        out_valid, out_tid, out_pre_valid, halted;
    logic [3:0]  out_pre;
    logic [1:0]  thread_halted;

    logic [15:0] w_imem_addr, w_imem_rdata, w_out_inst, w_out_pc;
    logic        w_out_valid, w_out_tid, w_out_pre_valid, w_halted;
    logic [3:0]  w_out_pre;
    logic [1:0]  w_thread_halted;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0100) return 16'hF00A;
        if (a == 16'h0101) return 16'h8005;
        return a;
    endfunction

    assign imem_rdata   = mem_word(imem_addr);
    assign w_imem_rdata = {4'h0, w_imem_addr[11:0]};

    sik_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halt_tid       (halt_tid),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_tid        (out_tid),
        .out_pre        (out_pre),
        .out_pre_valid  (out_pre_valid),
        .thread_halted  (thread_halted),
        .halted         (halted)
    );

    sik_fetch #(
        .T0_RESET_PC (16'hFFFF),
        .T1_RESET_PC (16'h8000)
    ) dut_w (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (w_imem_addr),
        .imem_rdata     (w_imem_rdata),
        .stall          (1'b0),
        .redirect_valid (1'b0),
        .redirect_tid   (1'b0),
        .redirect_pc    (16'h0000),
        .halt_req       (1'b0),
        .halt_tid       (1'b0),
        .out_valid      (w_out_valid),
        .out_inst       (w_out_inst),
        .out_pc         (w_out_pc),
        .out_tid        (w_out_tid),
        .out_pre        (w_out_pre),
        .out_pre_valid  (w_out_pre_valid),
        .thread_halted  (w_thread_halted),
        .halted         (w_halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void push(input logic tid, input logic [15:0] pc, input logic [15:0] inst,
                                 input logic [3:0] pre, input logic pre_v);
        exp_t e;
        e.tid   = tid;
        e.pc    = pc;
        e.inst  = inst;
        e.pre   = pre;
        e.pre_v = pre_v;
        q.push_back(e);
    endfunction

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare each live output; pop only when decode takes it (no stall)
    always @(negedge clk) begin
        logic sq;
        exp_t e;
        if (!reset && out_valid) begin
            sq = (redirect_valid && redirect_tid == out_tid) || (halt_req && halt_tid == out_tid);
            if (!sq) begin
                if (q.size() == 0) begin
                    check_eq("sb_unexpected_out", {16'h0, out_pc}, 32'hFFFF_FFFF);
                end else begin
                    e = q[0];
                    check_eq("out_tid", {31'h0, out_tid}, {31'h0, e.tid});
                    check_eq("out_pc", {16'h0, out_pc}, {16'h0, e.pc});
                    check_eq("out_inst", {16'h0, out_inst}, {16'h0, e.inst});
                    check_eq("out_pre_valid", {31'h0, out_pre_valid}, {31'h0, e.pre_v});
                    check_eq("out_pre", {28'h0, out_pre}, {28'h0, e.pre});
                    if (!stall) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check_eq("rst_out_inst", {16'h0, out_inst}, 32'h0);
        check_eq("rst_out_pc", {16'h0, out_pc}, 32'h0);
        check_eq("rst_out_tid", {31'h0, out_tid}, 32'h0);
        check_eq("rst_out_pre_valid", {31'h0, out_pre_valid}, 32'h0);
        check_eq("rst_out_pre", {28'h0, out_pre}, 32'h0);
        check_eq("rst_thread_halted", {30'h0, thread_halted}, 32'h0);
        check_eq("rst_halted", {31'h0, halted}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Round-robin from reset PCs
        push(1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0);
        push(1'b1, 16'h8000, 16'h8000, 4'h0, 1'b0);
        push(1'b0, 16'h0001, 16'h0001, 4'h0, 1'b0);
        push(1'b1, 16'h8001, 16'h8001, 4'h0, 1'b0);
        edges(1);
        check_eq("lat_out_valid_e1", {31'h0, out_valid}, 32'h0);
        check_eq("imem_addr_e1", {16'h0, imem_addr}, 32'h0000);
        edges(1);
        check_eq("wrap_valid", {31'h0, w_out_valid}, 32'h1);
        check_eq("wrap_pc_ffff", {16'h0, w_out_pc}, 32'hFFFF);
        check_eq("wrap_tid0", {31'h0, w_out_tid}, 32'h0);
        edges(1);
        check_eq("wrap_pc_t1", {16'h0, w_out_pc}, 32'h8000);
        edges(1);
        check_eq("wrap_pc_0000", {16'h0, w_out_pc}, 32'h0000);
        check_eq("wrap_tid0_b", {31'h0, w_out_tid}, 32'h0);

        // Stall for three edges while (0,0001) is presented
        stall = 1'b1;
        edges(1);
        check_eq("stall_imem_addr", {16'h0, imem_addr}, 32'h8001);
        edges(2);
        stall = 1'b0;

        // Redirect thread 0 to 0x0040
        edges(2);
        push(1'b1, 16'h8002, 16'h8002, 4'h0, 1'b0);
        push(1'b1, 16'h8003, 16'h8003, 4'h0, 1'b0);
        push(1'b0, 16'h0040, 16'h0040, 4'h0, 1'b0);
        push(1'b1, 16'h8004, 16'h8004, 4'h0, 1'b0);
        push(1'b0, 16'h0041, 16'h0041, 4'h0, 1'b0);
        redirect_valid = 1'b1;
        redirect_tid   = 1'b0;
        redirect_pc    = 16'h0040;
        edges(1);
        redirect_valid = 1'b0;

        // Halt thread 1
        edges(5);
        push(1'b0, 16'h0042, 16'h0042, 4'h0, 1'b0);
        halt_req = 1'b1;
        halt_tid = 1'b1;
        edges(1);
        halt_req = 1'b0;
        check_eq("halt_t1_flags", {30'h0, thread_halted}, 32'h2);
        check_eq("halt_t1_halted", {31'h0, halted}, 32'h0);

        // Prefix folding on thread 0 at 0x0100
        edges(2);
`ifdef SIK_PRE_FOLD_EN
        push(1'b0, 16'h0101, 16'h8005, 4'hA, 1'b1);
`else
        push(1'b0, 16'h0100, 16'hF00A, 4'h0, 1'b0);
        push(1'b0, 16'h0101, 16'h8005, 4'h0, 1'b0);
`endif
        push(1'b0, 16'h0102, 16'h0102, 4'h0, 1'b0);
        redirect_valid = 1'b1;
        redirect_tid   = 1'b0;
        redirect_pc    = 16'h0100;
        edges(1);
        redirect_valid = 1'b0;

        // Halt thread 0 too: pipe must drain
        edges(5);
        halt_req = 1'b1;
        halt_tid = 1'b0;
        edges(1);
        halt_req = 1'b0;
        check_eq("halt_both_flags", {30'h0, thread_halted}, 32'h3);
        check_eq("halt_both_out_valid", {31'h0, out_valid}, 32'h0);
        check_eq("halt_both_halted", {31'h0, halted}, 32'h1);
        edges(3);
        check_eq("halted_sticky", {31'h0, halted}, 32'h1);
        check_eq("sb_drained", q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
